nmcu_core: RTL and testbench

Near-memory compute unit: a single-ported instruction slave that owns a local word-addressed SRAM and executes CPU-issued STORE, LOAD and MAC (dot-product) instructions next to the memory. It sits behind the CPU instruction channel. It returns results over a valid/ready response channel. One instruction is in flight at a time.

---
 rtl/instr_pkg.sv | 18 +
 rtl/nmcu_pkg.sv | 18 +
 rtl/nmcu_mem.sv | 25 ++
 rtl/nmcu_core.sv | 137 +++++++++++++
 tb/tb_nmcu_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// CPU instruction format: opcode plus three word addresses, store data and MAC length.
package instr_pkg;
    typedef enum logic [2:0] {
        INSTR_NOP   = 3'd0,
        INSTR_LOAD  = 3'd1,
        INSTR_STORE = 3'd2,
        INSTR_MAC   = 3'd3
    } opcode_t;

    typedef struct packed {
        opcode_t                             opcode;
        logic [nmcu_pkg::ADDR_WIDTH-1:0]     addr_a;
        logic [nmcu_pkg::ADDR_WIDTH-1:0]     addr_b;
        logic [nmcu_pkg::ADDR_WIDTH-1:0]     addr_c;
        logic [nmcu_pkg::DATA_WIDTH-1:0]     data;
        logic [nmcu_pkg::LEN_WIDTH-1:0]      len;
    } instruction_t;
endpackage

// File: rtl/nmcu_pkg.sv
// Shared widths, response format and FSM state codes for the near-memory compute unit.
package nmcu_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } nmcu_cpu_resp_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_RD = 3'd1;
    localparam logic [2:0] ST_MAC_RD  = 3'd2;
    localparam logic [2:0] ST_MAC_ACC = 3'd3;
    localparam logic [2:0] ST_MAC_WR  = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;
endpackage

// File: rtl/nmcu_mem.sv
// Local word SRAM: two registered read ports and one write port; contents are not reset.
module nmcu_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Reads return the pre-write contents when the addresses collide.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end
endmodule

// File: rtl/nmcu_core.sv
// Near-memory compute unit: executes STORE / LOAD / MAC against the local SRAM, one
// instruction at a time, and returns results over a valid/ready response channel.
module nmcu_core
    import nmcu_pkg::*;
    import instr_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_instr_valid,
    input  instruction_t   cpu_instruction,
    output logic           cpu_instr_ready,
    output logic           nmcu_resp_valid_o,
    input  logic           nmcu_resp_ready_i,
    output nmcu_cpu_resp_t nmcu_response_o,
    output logic [2:0]     dbg_state
);
    // Handshakes: an instruction transfers on a rising edge with cpu_instr_valid &&
    // cpu_instr_ready; a response transfers on a rising edge with nmcu_resp_valid_o &&
    // nmcu_resp_ready_i, and valid/data are held unchanged until that edge.

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q, addr_c_q;
    logic [LEN_WIDTH-1:0]  len_q, idx_q;
    logic [DATA_WIDTH-1:0] acc_q, rd_a, rd_b, prod;
    logic [LEN_WIDTH:0]    idx_next;
    logic                  accept, more_elems;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr, rd_addr_a, rd_addr_b;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign cpu_instr_ready = (state == ST_IDLE) && !nmcu_resp_valid_o;
    assign accept          = cpu_instr_valid && cpu_instr_ready;
    assign prod            = rd_a * rd_b;
    assign idx_next        = {1'b0, idx_q} + 1'b1;
    assign more_elems      = idx_next < {1'b0, len_q};
    assign dbg_state       = state;

    // In IDLE the read port follows the incoming instruction so a LOAD's data is
    // registered on the accept edge itself.
    always_comb begin
        rd_addr_a = addr_a_q + ADDR_WIDTH'(idx_q);
        rd_addr_b = addr_b_q + ADDR_WIDTH'(idx_q);
        if (state == ST_IDLE) begin
            rd_addr_a = cpu_instruction.addr_a;
        end
        mem_we    = 1'b0;
        mem_waddr = cpu_instruction.addr_a;
        mem_wdata = cpu_instruction.data;
        if (!rst) begin
            if (accept && cpu_instruction.opcode == INSTR_STORE) begin
                mem_we = 1'b1;
            end else if (state == ST_MAC_WR) begin
                mem_we    = 1'b1;
                mem_waddr = addr_c_q;
                mem_wdata = acc_q;
            end
        end
    end

    nmcu_mem #(
        .ADDR_W (ADDR_WIDTH),
        .DATA_W (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            nmcu_resp_valid_o <= 1'b0;
            nmcu_response_o   <= '0;
            acc_q             <= '0;
            idx_q             <= '0;
            len_q             <= '0;
            addr_a_q          <= '0;
            addr_b_q          <= '0;
            addr_c_q          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_a_q <= cpu_instruction.addr_a;
                        addr_b_q <= cpu_instruction.addr_b;
                        addr_c_q <= cpu_instruction.addr_c;
                        len_q    <= cpu_instruction.len;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        case (cpu_instruction.opcode)
                            INSTR_LOAD:  state <= ST_LOAD_RD;
                            INSTR_STORE: state <= ST_IDLE;
                            INSTR_MAC:   state <= (cpu_instruction.len == '0) ? ST_MAC_WR : ST_MAC_RD;
                            default: begin
                                nmcu_response_o   <= '{data: '0, err: 1'b1};
                                nmcu_resp_valid_o <= 1'b1;
                                state             <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_LOAD_RD: begin
                    nmcu_response_o   <= '{data: rd_a, err: 1'b0};
                    nmcu_resp_valid_o <= 1'b1;
                    state             <= ST_RESP;
                end
                ST_MAC_RD: state <= ST_MAC_ACC;
                ST_MAC_ACC: begin
                    acc_q <= acc_q + prod;
                    if (more_elems) begin
                        idx_q <= idx_next[LEN_WIDTH-1:0];
                        state <= ST_MAC_RD;
                    end else begin
                        state <= ST_MAC_WR;
                    end
                end
                ST_MAC_WR: begin
                    nmcu_response_o   <= '{data: acc_q, err: 1'b0};
                    nmcu_resp_valid_o <= 1'b1;
                    state             <= ST_RESP;
                end
                ST_RESP: begin
                    if (nmcu_resp_valid_o && nmcu_resp_ready_i) begin
                        nmcu_resp_valid_o <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nmcu_core.sv
// Bench for nmcu_core: directed vector table, stall/reset sequences, then randomized
// instructions checked against a word-array reference of the memory.
module tb_nmcu_core;
    import nmcu_pkg::*;
    import instr_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           cpu_instr_valid;
    instruction_t   cpu_instruction;
    logic           cpu_instr_ready;
    logic           nmcu_resp_valid_o;
    logic           nmcu_resp_ready_i;
    nmcu_cpu_resp_t nmcu_response_o;
    logic [2:0]     dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [256];
    logic [32:0] exp_q [$];

    typedef struct {
        opcode_t     op;
        logic [7:0]  a, b, c;
        logic [31:0] data;
        logic [7:0]  len;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs [$];

    nmcu_core dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_instr_valid   (cpu_instr_valid),
        .cpu_instruction   (cpu_instruction),
        .cpu_instr_ready   (cpu_instr_ready),
        .nmcu_resp_valid_o (nmcu_resp_valid_o),
        .nmcu_resp_ready_i (nmcu_resp_ready_i),
        .nmcu_response_o   (nmcu_response_o),
        .dbg_state         (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mac_ref(input logic [7:0] a, input logic [7:0] b, input int len);
        logic [31:0] s;
        logic [7:0]  aa, bb;
        s = 0;
        for (int i = 0; i < len; i++) begin
            aa = a + 8'(i);
            bb = b + 8'(i);
            s  = s + model_mem[aa] * model_mem[bb];
        end
        return s;
    endfunction

    // Issues one instruction and, for non-STORE, checks latency and the response.
    // Starts and ends just after a falling edge.
    task automatic run_instr(input opcode_t op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [31:0] data, input logic [7:0] len,
                             input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                             input string name);
        int k;
        logic [32:0] exp;
        k = 0;
        while (!cpu_instr_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({name, "_ready_before"}, 32'(cpu_instr_ready), 32'd1);
        cpu_instruction = '{opcode: op, addr_a: a, addr_b: b, addr_c: c, data: data, len: len};
        cpu_instr_valid = 1'b1;
        if (op == INSTR_STORE) model_mem[a] = data;
        else if (op == INSTR_MAC) model_mem[c] = mac_ref(a, b, int'(len));
        if (op != INSTR_STORE) exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        @(negedge clk);
        cpu_instr_valid = 1'b0;
        if (op == INSTR_STORE) begin
            check({name, "_store_ready"}, 32'(cpu_instr_ready), 32'd1);
            return;
        end
        k = 0;
        while (!nmcu_resp_valid_o && k < 600) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, 32'(nmcu_resp_valid_o), 32'd1);
        if (exp_lat >= 0) check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_ready_low"}, 32'(cpu_instr_ready), 32'd0);
        exp = exp_q.pop_front();
        check({name, "_data"}, nmcu_response_o.data, exp[31:0]);
        check({name, "_err"}, 32'(nmcu_response_o.err), 32'(exp[32]));
        @(negedge clk);
        check({name, "_valid_drop"}, 32'(nmcu_resp_valid_o), 32'd0);
        check({name, "_ready_back"}, 32'(cpu_instr_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          k;
        rst               = 1'b1;
        cpu_instr_valid   = 1'b0;
        cpu_instruction   = '0;
        nmcu_resp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cpu_instr_ready), 32'd1);
        check("rst_valid", 32'(nmcu_resp_valid_o), 32'd0);
        check("rst_resp", nmcu_response_o.data, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        vecs.push_back('{INSTR_STORE, 8'd100, 8'd0, 8'd0, 32'd55, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd101, 8'd0, 8'd0, 32'd2, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_LOAD, 8'd100, 8'd0, 8'd0, 32'd0, 8'd0, 32'd55, 1'b0, 1});
        vecs.push_back('{INSTR_MAC, 8'd100, 8'd101, 8'd200, 32'd0, 8'd1, 32'd110, 1'b0, 3});
        vecs.push_back('{INSTR_LOAD, 8'd200, 8'd0, 8'd0, 32'd0, 8'd0, 32'd110, 1'b0, 1});
        vecs.push_back('{INSTR_STORE, 8'd10, 8'd0, 8'd0, 32'd1, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd11, 8'd0, 8'd0, 32'd2, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd12, 8'd0, 8'd0, 32'd3, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd20, 8'd0, 8'd0, 32'd4, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd21, 8'd0, 8'd0, 32'd5, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd22, 8'd0, 8'd0, 32'd6, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_MAC, 8'd10, 8'd20, 8'd30, 32'd0, 8'd3, 32'd32, 1'b0, 7});
        vecs.push_back('{INSTR_LOAD, 8'd30, 8'd0, 8'd0, 32'd0, 8'd0, 32'd32, 1'b0, 1});
        vecs.push_back('{INSTR_STORE, 8'd255, 8'd0, 8'd0, 32'hFFFF_FFFF, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd50, 8'd0, 8'd0, 32'd2, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_MAC, 8'd255, 8'd50, 8'd60, 32'd0, 8'd1, 32'hFFFF_FFFE, 1'b0, 3});
        vecs.push_back('{INSTR_STORE, 8'd0, 8'd0, 8'd0, 32'd1, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_STORE, 8'd51, 8'd0, 8'd0, 32'd3, 8'd0, 32'd0, 1'b0, -1});
        vecs.push_back('{INSTR_MAC, 8'd255, 8'd50, 8'd61, 32'd0, 8'd2, 32'd1, 1'b0, 5});
        vecs.push_back('{INSTR_LOAD, 8'd61, 8'd0, 8'd0, 32'd0, 8'd0, 32'd1, 1'b0, 1});
        vecs.push_back('{INSTR_MAC, 8'd10, 8'd20, 8'd30, 32'd0, 8'd0, 32'd0, 1'b0, 1});
        vecs.push_back('{INSTR_LOAD, 8'd30, 8'd0, 8'd0, 32'd0, 8'd0, 32'd0, 1'b0, 1});
        vecs.push_back('{INSTR_MAC, 8'd10, 8'd20, 8'd10, 32'd0, 8'd3, 32'd32, 1'b0, 7});
        vecs.push_back('{INSTR_LOAD, 8'd10, 8'd0, 8'd0, 32'd0, 8'd0, 32'd32, 1'b0, 1});
        vecs.push_back('{INSTR_LOAD, 8'd11, 8'd0, 8'd0, 32'd0, 8'd0, 32'd2, 1'b0, 1});
        vecs.push_back('{INSTR_NOP, 8'd1, 8'd2, 8'd3, 32'd9, 8'd4, 32'd0, 1'b1, -1});
        vecs.push_back('{opcode_t'(3'd6), 8'd1, 8'd2, 8'd3, 32'd9, 8'd4, 32'd0, 1'b1, -1});

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].data, vecs[i].len,
                      vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Response back-pressure: outputs hold and a valid instruction is not taken.
        nmcu_resp_ready_i = 1'b0;
        cpu_instruction   = '{opcode: INSTR_LOAD, addr_a: 8'd100, addr_b: 8'd0, addr_c: 8'd0, data: 32'd0, len: 8'd0};
        cpu_instr_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_instr_valid = 1'b0;
        k = 0;
        while (!nmcu_resp_valid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(nmcu_resp_valid_o), 32'd1);
            check("stall_data", nmcu_response_o.data, 32'd55);
            check("stall_ready", 32'(cpu_instr_ready), 32'd0);
            cpu_instruction = '{opcode: INSTR_STORE, addr_a: 8'd100, addr_b: 8'd0, addr_c: 8'd0, data: 32'd999, len: 8'd0};
            cpu_instr_valid = 1'b1;
            @(negedge clk);
        end
        cpu_instr_valid   = 1'b0;
        nmcu_resp_ready_i = 1'b1;
        check("stall_data_end", nmcu_response_o.data, 32'd55);
        @(negedge clk);
        check("stall_valid_drop", 32'(nmcu_resp_valid_o), 32'd0);
        run_instr(INSTR_LOAD, 8'd100, 8'd0, 8'd0, 32'd0, 8'd0, 32'd55, 1'b0, 1, "stall_ignored");

        // Reset during the read phase of a MAC must leave its destination untouched.
        run_instr(INSTR_STORE, 8'd40, 8'd0, 8'd0, 32'd3, 8'd0, 32'd0, 1'b0, -1, "rs_st0");
        run_instr(INSTR_STORE, 8'd41, 8'd0, 8'd0, 32'd4, 8'd0, 32'd0, 1'b0, -1, "rs_st1");
        run_instr(INSTR_STORE, 8'd45, 8'd0, 8'd0, 32'd777, 8'd0, 32'd0, 1'b0, -1, "rs_st2");
        cpu_instruction = '{opcode: INSTR_MAC, addr_a: 8'd40, addr_b: 8'd41, addr_c: 8'd45, data: 32'd0, len: 8'd3};
        cpu_instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_instr_valid = 1'b0;
        check("rs_in_mac_rd", 32'(dbg_state), 32'(ST_MAC_RD));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rs_ready", 32'(cpu_instr_ready), 32'd1);
        check("rs_valid", 32'(nmcu_resp_valid_o), 32'd0);
        check("rs_state", 32'(dbg_state), 32'(ST_IDLE));
        run_instr(INSTR_LOAD, 8'd45, 8'd0, 8'd0, 32'd0, 8'd0, 32'd777, 1'b0, 1, "rs_load");

        // Randomized traffic inside a region the model fully initialises.
        for (int i = 64; i < 128; i++) begin
            v = $urandom;
            run_instr(INSTR_STORE, 8'(i), 8'd0, 8'd0, v, 8'd0, 32'd0, 1'b0, -1, "rnd_init");
        end
        for (int n = 0; n < 40; n++) begin
            int          kind, len;
            logic [7:0]  a, b, c;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(0, 8);
            a    = 8'($urandom_range(64, 127 - len));
            b    = 8'($urandom_range(64, 127 - len));
            c    = 8'($urandom_range(64, 127));
            if (kind == 0) begin
                run_instr(INSTR_LOAD, a, 8'd0, 8'd0, 32'd0, 8'd0, model_mem[a], 1'b0, 1, "rnd_load");
            end else if (kind == 3) begin
                v = $urandom;
                run_instr(INSTR_STORE, c, 8'd0, 8'd0, v, 8'd0, 32'd0, 1'b0, -1, "rnd_store");
            end else begin
                run_instr(INSTR_MAC, a, b, c, 32'd0, 8'(len), mac_ref(a, b, len), 1'b0,
                          (len == 0) ? 1 : 2 * len + 1, "rnd_mac");
            end
        end
        for (int i = 64; i < 128; i += 7) begin
            run_instr(INSTR_LOAD, 8'(i), 8'd0, 8'd0, 32'd0, 8'd0, model_mem[i], 1'b0, 1, "rnd_final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
